// File: rtl/eae_arith_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eae_arith_unit_pkg
//  Description : Operation codes and FSM state encodings shared by the
//                PDP-8/e EAE (mode A) arithmetic engine and its users.
//  Revision    : 1.0 - initial release
// ============================================================================
package eae_arith_unit_pkg;

    // EAE mode A operation codes
    localparam logic [2:0] OP_MUY = 3'd0;
    localparam logic [2:0] OP_DVI = 3'd1;
    localparam logic [2:0] OP_NMI = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;
    localparam logic [2:0] OP_LSR = 3'd5;

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/eae_divstep.sv
`default_nettype none
// ============================================================================
//  Module      : eae_divstep
//  Description : One combinational restoring-division step. {rem,MQ} is
//                shifted left one place and the divisor is subtracted from
//                the partial remainder when it fits. mq_nxt carries the
//                shifted MQ with a 0 in the vacated bit; the caller merges
//                qbit into that position.
//  Revision    : 1.0 - initial release
// ============================================================================
module eae_divstep #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] mq_nxt,
    output logic             qbit
);

    logic [WIDTH:0] w_shifted;

    // Shift, trial-compare against the divisor, and restore when it does not fit
    always_comb begin
        w_shifted = {rem, mq[WIDTH-1]};
        qbit      = (w_shifted >= {1'b0, div});
        rem_nxt   = qbit ? WIDTH'(w_shifted - {1'b0, div}) : w_shifted[WIDTH-1:0];
        mq_nxt    = {mq[WIDTH-2:0], 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/eae_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : eae_arith_unit
//  Description : Iterative PDP-8/e EAE mode A engine (MUY, DVI, NMI, SHL,
//                ASR, LSR). Operands are captured on start, one step runs
//                per clock, and results are registered on the step that
//                finishes so they are valid in the single done cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module eae_arith_unit #(
    parameter int WIDTH = 12,
    parameter int SCW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic             link_in,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] mq_out,
    output logic             link_out,
    output logic [SCW-1:0]   sc_out
);
    import eae_arith_unit_pkg::*;

    // MUY and DVI both run exactly WIDTH steps
    localparam logic [SCW-1:0] c_LAST_STEP = SCW'(WIDTH - 1);

    // NMI stops when the top two AC bits differ or the whole {AC,MQ} is zero
    function automatic logic f_nmi_stop(input logic [WIDTH-1:0] ac,
                                        input logic [WIDTH-1:0] mq);
        return (ac[WIDTH-1] != ac[WIDTH-2]) || ((ac == '0) && (mq == '0));
    endfunction

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_div;
    logic [SCW-1:0]   r_lim;
    logic [WIDTH-1:0] r_ac;
    logic [WIDTH-1:0] r_mq;
    logic             r_l;
    logic [SCW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_ac_out;
    logic [WIDTH-1:0] r_mq_out;
    logic             r_l_out;
    logic [SCW-1:0]   r_sc_out;

    logic [WIDTH-1:0] w_ac;
    logic [WIDTH-1:0] w_mq;
    logic             w_l;
    logic [SCW-1:0]   w_cnt;
    logic             w_fin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_mq;
    logic             w_div_q;

    eae_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .rem     (r_ac),
        .mq      (r_mq),
        .div     (r_div),
        .rem_nxt (w_div_rem),
        .mq_nxt  (w_div_mq),
        .qbit    (w_div_q)
    );

    // Next working values: operand capture in IDLE, one arithmetic step in RUN
    always_comb begin
        w_ac  = r_ac;
        w_mq  = r_mq;
        w_l   = r_l;
        w_cnt = r_cnt;
        w_fin = 1'b0;
        // Multiply step: conditional add of the multiplicand, carry kept for the shift
        w_sum = {1'b0, r_ac} + (r_mq[0] ? {1'b0, r_div} : {(WIDTH+1){1'b0}});
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ac  = ac_in;
                    w_mq  = mq_in;
                    w_l   = link_in;
                    w_cnt = '0;
                    case (op)
                        OP_MUY: w_l = 1'b0;
                        OP_DVI: begin
                            // Quotient would not fit: report overflow and leave AC/MQ alone
                            if (ac_in >= operand) begin
                                w_l   = 1'b1;
                                w_fin = 1'b1;
                            end else begin
                                w_l   = 1'b0;
                            end
                        end
                        OP_NMI: w_fin = f_nmi_stop(ac_in, mq_in);
                        OP_SHL: w_l   = link_in;
                        OP_ASR: w_l   = ac_in[WIDTH-1];
                        OP_LSR: w_l   = 1'b0;
                        default: w_fin = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt = r_cnt + 1'b1;
                case (r_op)
                    OP_MUY: begin
                        w_ac  = w_sum[WIDTH:1];
                        w_mq  = {w_sum[0], r_mq[WIDTH-1:1]};
                        w_fin = (r_cnt == c_LAST_STEP);
                    end
                    OP_DVI: begin
                        w_ac  = w_div_rem;
                        w_mq  = w_div_mq | WIDTH'(w_div_q);
                        w_fin = (r_cnt == c_LAST_STEP);
                    end
                    OP_NMI: begin
                        w_ac  = {r_ac[WIDTH-2:0], r_mq[WIDTH-1]};
                        w_mq  = {r_mq[WIDTH-2:0], 1'b0};
                        w_fin = f_nmi_stop(w_ac, w_mq);
                    end
                    OP_SHL: begin
                        w_l   = r_ac[WIDTH-1];
                        w_ac  = {r_ac[WIDTH-2:0], r_mq[WIDTH-1]};
                        w_mq  = {r_mq[WIDTH-2:0], 1'b0};
                        w_fin = (r_cnt == r_lim);
                    end
                    OP_ASR: begin
                        w_ac  = {r_ac[WIDTH-1], r_ac[WIDTH-1:1]};
                        w_mq  = {r_ac[0], r_mq[WIDTH-1:1]};
                        w_fin = (r_cnt == r_lim);
                    end
                    OP_LSR: begin
                        w_ac  = {1'b0, r_ac[WIDTH-1:1]};
                        w_mq  = {r_ac[0], r_mq[WIDTH-1:1]};
                        w_fin = (r_cnt == r_lim);
                    end
                    default: w_fin = 1'b1;
                endcase
            end
            default: begin
                w_fin = 1'b0;
            end
        endcase
    end

    // Sequencer, working registers, and result capture on the finishing step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUY;
            r_div    <= '0;
            r_lim    <= '0;
            r_ac     <= '0;
            r_mq     <= '0;
            r_l      <= 1'b0;
            r_cnt    <= '0;
            r_ac_out <= '0;
            r_mq_out <= '0;
            r_l_out  <= 1'b0;
            r_sc_out <= '0;
        end else begin
            r_ac  <= w_ac;
            r_mq  <= w_mq;
            r_l   <= w_l;
            r_cnt <= w_cnt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_div   <= operand;
                        r_lim   <= operand[SCW-1:0];
                        r_state <= w_fin ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fin) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_fin) begin
                r_ac_out <= w_ac;
                r_mq_out <= w_mq;
                r_l_out  <= w_l;
                // Only NMI reports a step count; it equals the shifts performed
                r_sc_out <= ((r_state == S_RUN) && (r_op == OP_NMI)) ? w_cnt : '0;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign ac_out   = r_ac_out;
    assign mq_out   = r_mq_out;
    assign link_out = r_l_out;
    assign sc_out   = r_sc_out;

endmodule
`default_nettype wire

// File: tb/tb_eae_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eae_arith_unit
//  Description : Self-checking bench for eae_arith_unit. A behavioural model
//                computes the expected results and latency of each operation
//                from plain arithmetic; a negedge monitor compares busy,
//                done and the result outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eae_arith_unit;
    import eae_arith_unit_pkg::*;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [2:0]  op      = 3'd0;
    logic [11:0] ac_in   = 12'd0;
    logic [11:0] mq_in   = 12'd0;
    logic        link_in = 1'b0;
    logic [11:0] operand = 12'd0;
    logic        busy;
    logic        done;
    logic [11:0] ac_out;
    logic [11:0] mq_out;
    logic        link_out;
    logic [4:0]  sc_out;

    eae_arith_unit #(
        .WIDTH (12),
        .SCW   (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .ac_in    (ac_in),
        .mq_in    (mq_in),
        .link_in  (link_in),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .ac_out   (ac_out),
        .mq_out   (mq_out),
        .link_out (link_out),
        .sc_out   (sc_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int issued = 0;
    int completed = 0;
    int st_cyc = 0;
    int abort_at = 32'h3fff_ffff;

    logic [11:0] exp_ac, exp_mq;
    logic        exp_l;
    logic [4:0]  exp_sc;
    int          exp_lat;
    int          lit_ac, lit_mq, lit_l, lit_sc, lit_lat;
    logic [11:0] h_ac = 12'd0, h_mq = 12'd0;
    logic        h_l = 1'b0;
    logic [4:0]  h_sc = 5'd0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0o (octal), expected %0o (octal) at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Expected results and done latency straight from the instruction definitions
    task automatic model(input logic [2:0] o, input logic [11:0] a, input logic [11:0] m,
                         input logic lk, input logic [11:0] d);
        longint v;
        int     n;
        int     k;
        exp_ac  = a;
        exp_mq  = m;
        exp_l   = lk;
        exp_sc  = 5'd0;
        exp_lat = 1;
        n = int'(d[4:0]) + 1;
        case (o)
            OP_MUY: begin
                v = longint'(m) * longint'(d) + longint'(a);
                exp_ac = v[23:12]; exp_mq = v[11:0]; exp_l = 1'b0; exp_lat = 13;
            end
            OP_DVI: begin
                if (a >= d) begin
                    exp_l = 1'b1;
                end else begin
                    v = longint'({a, m});
                    exp_mq = 12'(v / longint'(d));
                    exp_ac = 12'(v % longint'(d));
                    exp_l = 1'b0; exp_lat = 13;
                end
            end
            OP_SHL: begin
                v = longint'({lk, a, m});
                v = (v << n) & 64'h1FF_FFFF;
                exp_l = v[24]; exp_ac = v[23:12]; exp_mq = v[11:0]; exp_lat = n + 1;
            end
            OP_ASR: begin
                v = longint'($signed({a, m}));
                v = v >>> n;
                exp_l = a[11]; exp_ac = v[23:12]; exp_mq = v[11:0]; exp_lat = n + 1;
            end
            OP_LSR: begin
                v = longint'({a, m});
                v = v >> n;
                exp_l = 1'b0; exp_ac = v[23:12]; exp_mq = v[11:0]; exp_lat = n + 1;
            end
            OP_NMI: begin
                v = longint'({a, m});
                k = 0;
                while (v != 0 && v[23] == v[22]) begin
                    v = (v << 1) & 64'hFF_FFFF;
                    k++;
                end
                exp_ac = v[23:12]; exp_mq = v[11:0]; exp_sc = 5'(k); exp_lat = k + 1;
            end
            default: ;
        endcase
    endtask

    // Cycle-by-cycle compare of the DUT against the model
    always @(negedge clk) begin : p_mon
        int d;
        if (issued != completed && cyc > st_cyc) begin
            d = cyc - st_cyc;
            if (cyc > abort_at) begin
                chk("abort busy", int'(busy), 0);
                chk("abort done", int'(done), 0);
                chk("abort ac", int'(ac_out), 0);
                chk("abort mq", int'(mq_out), 0);
                chk("abort link", int'(link_out), 0);
                chk("abort sc", int'(sc_out), 0);
                h_ac = 12'd0; h_mq = 12'd0; h_l = 1'b0; h_sc = 5'd0;
                completed++;
            end else begin
                chk("busy", int'(busy), int'(d < exp_lat));
                chk("done", int'(done), int'(d == exp_lat));
                if (d == exp_lat) begin
                    chk("ac", int'(ac_out), int'(exp_ac));
                    chk("mq", int'(mq_out), int'(exp_mq));
                    chk("link", int'(link_out), int'(exp_l));
                    chk("sc", int'(sc_out), int'(exp_sc));
                    if (lit_ac >= 0)  chk("literal ac", int'(ac_out), lit_ac);
                    if (lit_mq >= 0)  chk("literal mq", int'(mq_out), lit_mq);
                    if (lit_l >= 0)   chk("literal link", int'(link_out), lit_l);
                    if (lit_sc >= 0)  chk("literal sc", int'(sc_out), lit_sc);
                    if (lit_lat >= 0) chk("literal latency", d, lit_lat);
                    h_ac = exp_ac; h_mq = exp_mq; h_l = exp_l; h_sc = exp_sc;
                    completed++;
                end
            end
        end else if (issued == completed) begin
            chk("idle done", int'(done), 0);
            chk("idle busy", int'(busy), 0);
            chk("hold ac", int'(ac_out), int'(h_ac));
            chk("hold mq", int'(mq_out), int'(h_mq));
            chk("hold link", int'(link_out), int'(h_l));
            chk("hold sc", int'(sc_out), int'(h_sc));
        end
    end

    // Issue one operation; optionally a stray start or a reset at a given cycle
    task automatic run_op(input logic [2:0] o, input logic [11:0] a, input logic [11:0] m,
                          input logic lk, input logic [11:0] d,
                          input int la, input int lm, input int ll, input int ls, input int llat,
                          input int extra_at, input int rst_at);
        @(negedge clk);
        model(o, a, m, lk, d);
        lit_ac = la; lit_mq = lm; lit_l = ll; lit_sc = ls; lit_lat = llat;
        op = o; ac_in = a; mq_in = m; link_in = lk; operand = d;
        start = 1'b1;
        st_cyc = cyc;
        issued++;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == extra_at) begin
                start = 1'b1; op = OP_MUY;
                ac_in = 12'o1111; mq_in = 12'o2222; operand = 12'o3333; link_in = 1'b1;
            end
            if (i == rst_at) begin
                reset = 1'b1;
                abort_at = cyc;
            end
            if (issued == completed && i > extra_at) break;
            if (i == 100) begin
                $display("FAIL timeout: operation never completed, expected latency %0d", exp_lat);
                $fatal(1, "timeout");
            end
        end
        start = 1'b0;
        if (rst_at > 0) begin
            @(negedge clk);
            reset = 1'b0;
            abort_at = 32'h3fff_ffff;
        end
    endtask

    initial begin
        logic [11:0] ra, rm, rd;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(OP_MUY, 12'o0005, 12'o0012, 1'b0, 12'o0013, 'o0,    'o0163, 0, 0,     13, 0, 0);
        run_op(OP_MUY, 12'o7777, 12'o7777, 1'b1, 12'o7777, 'o7777, 'o0,    0, 0,     13, 0, 0);
        run_op(OP_DVI, 12'o0000, 12'o0144, 1'b0, 12'o0007, 'o0002, 'o0016, 0, 0,     13, 0, 0);
        run_op(OP_DVI, 12'o0007, 12'o0144, 1'b0, 12'o0007, 'o0007, 'o0144, 1, -1,    1, 0, 0);
        run_op(OP_DVI, 12'o0000, 12'o0123, 1'b0, 12'o0000, 'o0000, 'o0123, 1, -1,    1, 0, 0);
        run_op(OP_SHL, 12'o1234, 12'o5670, 1'b0, 12'o0002, 'o2345, 'o6700, 1, 0,      4, 0, 0);
        run_op(OP_SHL, 12'o1234, 12'o5670, 1'b0, 12'o0037, 'o0,    'o0,    0, 0,     33, 0, 0);
        run_op(OP_ASR, 12'o4000, 12'o0001, 1'b0, 12'o0000, 'o6000, 'o0,    1, -1,    2, 0, 0);
        run_op(OP_LSR, 12'o4000, 12'o0001, 1'b1, 12'o0000, 'o2000, 'o0,    0, -1,    2, 0, 0);
        run_op(OP_ASR, 12'o7000, 12'o0000, 1'b0, 12'o0037, 'o7777, 'o7777, 1, -1,   33, 0, 0);
        run_op(OP_NMI, 12'o0000, 12'o0001, 1'b1, 12'o0000, 'o2000, 'o0,    1, 'o26, 23, 0, 0);
        run_op(OP_NMI, 12'o0000, 12'o0000, 1'b0, 12'o0000, 'o0,    'o0,    0, 0,      1, 0, 0);
        run_op(OP_NMI, 12'o3777, 12'o1234, 1'b0, 12'o0000, 'o3777, 'o1234, 0, 0,      1, 0, 0);
        run_op(3'd6,   12'o1111, 12'o2222, 1'b1, 12'o3333, 'o1111, 'o2222, 1, 0,      1, 0, 0);
        // Reset in cycle 5 of a multiply: no done, outputs cleared
        run_op(OP_MUY, 12'o0005, 12'o0012, 1'b0, 12'o0013, -1, -1, -1, -1, -1, 0, 5);
        // Start while busy and start in the done cycle are both ignored
        run_op(OP_MUY, 12'o0005, 12'o0012, 1'b0, 12'o0013, 'o0,    'o0163, 0, 0,     13, 4, 0);
        run_op(OP_SHL, 12'o1234, 12'o5670, 1'b0, 12'o0000, 'o2471, 'o3560, 0, 0,      2, 2, 0);

        for (int t = 0; t < 4; t++) begin
            ra = 12'($urandom); rm = 12'($urandom); rd = 12'($urandom);
            run_op(OP_MUY, ra, rm, 1'b0, rd, -1, -1, -1, -1, -1, 0, 0);
            rd = 12'($urandom_range(1, 4095));
            ra = 12'($urandom_range(0, int'(rd) - 1));
            run_op(OP_DVI, ra, rm, 1'b1, rd, -1, -1, -1, -1, -1, 0, 0);
            run_op(OP_NMI, 12'($urandom_range(0, 63)), rm, 1'(t), 12'd0, -1, -1, -1, -1, -1, 0, 0);
            run_op(OP_ASR, ra, rm, 1'b0, 12'($urandom_range(0, 31)), -1, -1, -1, -1, -1, 0, 0);
            run_op(OP_SHL, ra, rm, 1'(t), 12'($urandom_range(0, 31)), -1, -1, -1, -1, -1, 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
